// File: rtl/a2d_spi_intf.sv
// SPI master for the 8-channel 12-bit line-sensor A2D: command frame, gap, result frame.
// Define A2D_INVERT_EN to present the bitwise-inverted conversion on res.
module a2d_spi_intf #(
  parameter int unsigned SCLK_DIV = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        strt_cnv,
  input  logic [2:0]  chnnl,
  output logic        cnv_cmplt,
  output logic [11:0] res,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  localparam int unsigned DivW = $clog2(SCLK_DIV);
  localparam logic [DivW-1:0] DivLast  = DivW'(SCLK_DIV - 1);
  localparam logic [DivW-1:0] HalfLast = DivW'(SCLK_DIV / 2 - 1);
  localparam logic [4:0] NumBits = 5'd16;

  typedef enum logic [1:0] {StIdle, StFrm1, StGap, StFrm2} state_e;

  state_e          state_q, state_d;
  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic [4:0]      bit_cnt_q, bit_cnt_d;
  logic [15:0]     tx_q, tx_d;
  // Only the low 12 received bits are ever used; older bits fall off the top.
  logic [11:0]     rx_q, rx_d;
  logic [2:0]      chnnl_q, chnnl_d;
  logic            ss_n_q, ss_n_d;
  logic            sclk_q, sclk_d;
  logic            cnv_cmplt_q, cnv_cmplt_d;
  logic [11:0]     res_q, res_d;

  logic        in_frame, rise_evt, fall_evt, frame_end, gap_end;
  logic [15:0] cmd;
  logic [11:0] res_new;

  assign in_frame  = (state_q == StFrm1) || (state_q == StFrm2);
  assign rise_evt  = in_frame && (div_cnt_q == DivLast);
  assign fall_evt  = in_frame && (div_cnt_q == HalfLast) && (bit_cnt_q != NumBits);
  // After the 16th rise SCLK stays high for half a period before SS_n releases.
  assign frame_end = in_frame && (div_cnt_q == HalfLast) && (bit_cnt_q == NumBits);
  assign gap_end   = (state_q == StGap) && (div_cnt_q == DivLast);
  assign cmd       = {2'b00, chnnl_q, 11'h000};

`ifdef A2D_INVERT_EN
  assign res_new = ~rx_q;
`else
  assign res_new = rx_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (strt_cnv)  state_d = StFrm1;
      StFrm1:  if (frame_end) state_d = StGap;
      StGap:   if (gap_end)   state_d = StFrm2;
      StFrm2:  if (frame_end) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    div_cnt_d   = div_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    chnnl_d     = chnnl_q;
    ss_n_d      = ss_n_q;
    sclk_d      = sclk_q;
    cnv_cmplt_d = cnv_cmplt_q;
    res_d       = res_q;
    unique case (state_q)
      StIdle: begin
        if (strt_cnv) begin
          chnnl_d     = chnnl;
          tx_d        = {2'b00, chnnl, 11'h000};
          cnv_cmplt_d = 1'b0;
          ss_n_d      = 1'b0;
          div_cnt_d   = '0;
          bit_cnt_d   = '0;
        end
      end
      StFrm1, StFrm2: begin
        div_cnt_d = div_cnt_q + DivW'(1);
        if (rise_evt) begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          rx_d      = {rx_q[10:0], MISO};
          sclk_d    = 1'b1;
        end
        if (fall_evt) begin
          sclk_d = 1'b0;
          // The first fall precedes any rise, so bit 15 is kept for the first sample.
          if (bit_cnt_q != 5'd0) tx_d = {tx_q[14:0], 1'b0};
        end
        if (frame_end) begin
          ss_n_d    = 1'b1;
          sclk_d    = 1'b1;
          div_cnt_d = '0;
          bit_cnt_d = '0;
          if (state_q == StFrm1) begin
            tx_d = cmd;
          end else begin
            res_d       = res_new;
            cnv_cmplt_d = 1'b1;
          end
        end
      end
      StGap: begin
        div_cnt_d = div_cnt_q + DivW'(1);
        if (gap_end) begin
          ss_n_d    = 1'b0;
          div_cnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      chnnl_q     <= '0;
      ss_n_q      <= 1'b1;
      sclk_q      <= 1'b1;
      cnv_cmplt_q <= 1'b0;
      res_q       <= '0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      chnnl_q     <= chnnl_d;
      ss_n_q      <= ss_n_d;
      sclk_q      <= sclk_d;
      cnv_cmplt_q <= cnv_cmplt_d;
      res_q       <= res_d;
    end
  end

  assign SS_n      = ss_n_q;
  assign SCLK      = sclk_q;
  assign MOSI      = tx_q[15];
  assign cnv_cmplt = cnv_cmplt_q;
  assign res       = res_q;

endmodule
